// File: rtl/exe_mem_stage_reg.sv
// Execute-to-memory pipeline register with the NZCV status register.
// Holds one instruction's result, store data, destination and control bits.
// The instruction that retires from execute updates sr when it carries the
// S flag. The block also counts every instruction that advances.
//
// state | meaning
// EMPTY | valid=0, this stage holds a bubble
// FULL  | valid=1, this stage holds a real instruction
module exe_mem_stage_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        s_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] st_val_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  status_in,
  output logic        valid,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic [31:0] alu_res,
  output logic [31:0] st_val,
  output logic [3:0]  dest,
  output logic [3:0]  sr,
  output logic [31:0] ex_count
);

  logic        r_valid;
  logic        r_wb_en;
  logic        r_mem_r_en;
  logic        r_mem_w_en;
  logic [31:0] r_alu_res;
  logic [31:0] r_st_val;
  logic [3:0]  r_dest;
  logic [3:0]  r_sr;
  logic [31:0] r_ex_count;

  logic w_adv;

  // A real instruction moves forward only when neither stalled nor squashed.
  // Any unfrozen cycle that does not advance inserts a bubble.
  assign w_adv = !freeze && !flush && in_valid;

  // Pipeline register, status register and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_alu_res  <= '0;
      r_st_val   <= '0;
      r_dest     <= '0;
      r_sr       <= '0;
      r_ex_count <= '0;
    end else if (!freeze) begin
      if (w_adv) begin
        r_valid    <= 1'b1;
        r_wb_en    <= wb_en_in;
        r_mem_r_en <= mem_r_en_in;
        r_mem_w_en <= mem_w_en_in;
        r_alu_res  <= alu_res_in;
        r_st_val   <= st_val_in;
        r_dest     <= dest_in;
        r_ex_count <= r_ex_count + 32'd1;
        if (s_in) begin
          r_sr <= status_in;
        end
      end else begin
        // Bubble: kill the control bits. Data is left stale because
        // nothing downstream consumes it while valid=0.
        r_valid    <= 1'b0;
        r_wb_en    <= 1'b0;
        r_mem_r_en <= 1'b0;
        r_mem_w_en <= 1'b0;
      end
    end
  end

  assign valid    = r_valid;
  assign wb_en    = r_wb_en;
  assign mem_r_en = r_mem_r_en;
  assign mem_w_en = r_mem_w_en;
  assign alu_res  = r_alu_res;
  assign st_val   = r_st_val;
  assign dest     = r_dest;
  assign sr       = r_sr;
  assign ex_count = r_ex_count;

endmodule
